// File: rtl/alu_arb_pkg.sv
// Shared ALU opcodes, FLAG bit positions and the per-opcode flag update mask.
// Pure definitions; no latency or flow control.
package alu_arb_pkg;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_XOR    = 3'b010;
    localparam logic [2:0] ALU_RED    = 3'b011;
    localparam logic [2:0] ALU_SLL    = 3'b100;
    localparam logic [2:0] ALU_SRA    = 3'b101;
    localparam logic [2:0] ALU_ROR    = 3'b110;
    localparam logic [2:0] ALU_PADDSB = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Arithmetic ops own all three flags; logical/shift ops only refresh Z.
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        logic [2:0] m;
        case (op)
            ALU_ADD:    m = 3'b111;
            ALU_SUB:    m = 3'b111;
            ALU_XOR:    m = 3'b001;
            ALU_RED:    m = 3'b001;
            ALU_SLL:    m = 3'b001;
            ALU_SRA:    m = 3'b001;
            ALU_ROR:    m = 3'b001;
            ALU_PADDSB: m = 3'b111;
            default:    m = 3'b001;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two ALU clients, a response consumer and the arbiter.
// master = client/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int DW = 16
);
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2:0]    req0_op;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [2:0]    req1_op;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_result;

    modport master (
        output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu.sv
// Existing combinational 16-bit ALU; zero latency, no flow control.
// FLAG merges freshly computed {N,V,Z} into FLAG_in under the opcode's update mask.
module alu
    import alu_arb_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] In1,
    input  logic [DW-1:0] In2,
    input  logic [2:0]    ALUOp,
    input  logic [2:0]    FLAG_in,
    output logic [2:0]    FLAG,
    output logic [DW-1:0] ALUOut
);
    localparam int SHW = $clog2(DW);
    localparam int NB  = DW / 8;
    localparam int NL  = DW / 4;

    logic [DW-1:0]  sum;
    logic [DW-1:0]  diff;
    logic [DW-1:0]  red_res;
    logic [DW-1:0]  padd_res;
    logic [DW-1:0]  sll_res;
    logic [DW-1:0]  sra_res;
    logic [DW-1:0]  ror_res;
    logic [SHW-1:0] sh;
    logic [NL-1:0]  padd_sat;
    logic           v_add;
    logic           v_sub;
    logic           ovf;
    logic [2:0]     fresh;
    logic [2:0]     mask;

    assign sh      = In2[SHW-1:0];
    assign sum     = In1 + In2;
    assign diff    = In1 - In2;
    assign v_add   = (In1[DW-1] == In2[DW-1]) && (sum[DW-1] != In1[DW-1]);
    assign v_sub   = (In1[DW-1] != In2[DW-1]) && (diff[DW-1] != In1[DW-1]);
    assign sll_res = In1 << sh;
    assign sra_res = $signed(In1) >>> sh;
    assign ror_res = DW'({In1, In1} >> sh);

    // Reduction: sum of all signed bytes of both operands, sign-extended.
    always_comb begin
        red_res = '0;
        for (int i = 0; i < NB; i++) begin
            red_res = red_res + {{(DW-8){In1[8*i+7]}}, In1[8*i +: 8]}
                              + {{(DW-8){In2[8*i+7]}}, In2[8*i +: 8]};
        end
    end

    // Nibble-wise signed saturating add.
    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic [4:0] s;
        assign s                  = {In1[4*i+3], In1[4*i +: 4]} + {In2[4*i+3], In2[4*i +: 4]};
        assign padd_sat[i]        = s[4] ^ s[3];
        assign padd_res[4*i +: 4] = padd_sat[i] ? (s[4] ? 4'h8 : 4'h7) : s[3:0];
    end

    always_comb begin
        ALUOut = '0;
        ovf    = 1'b0;
        case (ALUOp)
            ALU_ADD:    begin ALUOut = sum;  ovf = v_add; end
            ALU_SUB:    begin ALUOut = diff; ovf = v_sub; end
            ALU_XOR:    ALUOut = In1 ^ In2;
            ALU_RED:    ALUOut = red_res;
            ALU_SLL:    ALUOut = sll_res;
            ALU_SRA:    ALUOut = sra_res;
            ALU_ROR:    ALUOut = ror_res;
            ALU_PADDSB: begin ALUOut = padd_res; ovf = |padd_sat; end
            default:    ALUOut = '0;
        endcase
    end

    assign fresh = {ALUOut[DW-1], ovf, ~|ALUOut};
    assign mask  = flag_mask(ALUOp);
    assign FLAG  = (mask & fresh) | (~mask & FLAG_in);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational grant, rr_last advances only on a transfer.
// en=0 (downstream full or reset) withholds every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id,
    output logic       xfer
);
    logic rr_last;

    always_comb begin
        gnt_id = 1'b0;
        case (req)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~rr_last;
            default: gnt_id = 1'b0;
        endcase
        xfer = en && (req != 2'b00);
        gnt  = 2'b00;
        if (xfer) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // Reset to 1 so port 0 wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (xfer) begin
            rr_last <= gnt_id;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two ports (round-robin), owns FLAG {N,V,Z}; result 1 cycle after accept.
// Held unaccepted response drops both req_ready; ALU_ARB_STATS_EN adds saturating grant counters.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW = 16
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus,
    output logic [2:0]           flag_q
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
`endif
);
    logic          can_issue;
    logic [1:0]    gnt;
    logic          gnt_id;
    logic          xfer;
    logic [2:0]    iss_op;
    logic [DW-1:0] iss_a;
    logic [DW-1:0] iss_b;
    logic [DW-1:0] alu_out;
    logic [2:0]    alu_flag;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [DW-1:0] rsp_result_q;

    assign can_issue = !rsp_valid_q || bus.rsp_ready;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .en     (can_issue && !rst),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .xfer   (xfer)
    );

    assign bus.req_ready = gnt;

    assign iss_op = gnt_id ? bus.req1_op : bus.req0_op;
    assign iss_a  = gnt_id ? bus.req1_a  : bus.req0_a;
    assign iss_b  = gnt_id ? bus.req1_b  : bus.req0_b;

    // Flags are serialised through flag_q so back-to-back ops chain correctly.
    alu #(.DW(DW)) u_alu (
        .In1     (iss_a),
        .In2     (iss_b),
        .ALUOp   (iss_op),
        .FLAG_in (flag_q),
        .FLAG    (alu_flag),
        .ALUOut  (alu_out)
    );

    // A new transfer overwrites the buffer even while it is being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            flag_q       <= 3'b000;
        end else if (xfer) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= gnt_id;
            rsp_result_q <= alu_out;
            flag_q       <= alu_flag;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (xfer) begin
            if (!gnt_id && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if ( gnt_id && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios then randomized traffic,
// checked against a behavioural ALU/arbitration model.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DW(16)) bus();
    logic [2:0] flag_q;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    alu_share_arbiter #(.DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flag_q     (flag_q)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] m_flag = 3'b000;
    logic       m_rr_last = 1'b1;
    int         m_cnt0 = 0;
    int         m_cnt1 = 0;
    logic [1:0] take;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference ALU from the opcode definitions, using plain integer arithmetic.
    function automatic exp_t ref_alu(input logic id, input logic [2:0] op,
                                     input logic [15:0] a, input logic [15:0] b,
                                     input logic [2:0] fin);
        exp_t e;
        int   sa, sbv, s, sh, ua, t, x, y;
        bit   v, full;
        logic [15:0] r;
        sa = int'($signed(a));
        sbv = int'($signed(b));
        sh = int'(b[3:0]);
        ua = int'(a);
        v = 1'b0;
        full = (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_PADDSB);
        r = 16'h0;
        case (op)
            ALU_ADD: begin s = sa + sbv; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            ALU_SUB: begin s = sa - sbv; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            ALU_XOR: r = a ^ b;
            ALU_RED: begin
                s = int'($signed(a[7:0])) + int'($signed(a[15:8]))
                  + int'($signed(b[7:0])) + int'($signed(b[15:8]));
                r = s[15:0];
            end
            ALU_SLL: r = a << sh;
            ALU_SRA: begin s = sa >>> sh; r = s[15:0]; end
            ALU_ROR: begin t = (ua >> sh) | (ua << (16 - sh)); r = t[15:0]; end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    x = int'(a[4*i +: 4]); if (x > 7) x = x - 16;
                    y = int'(b[4*i +: 4]); if (y > 7) y = y - 16;
                    s = x + y;
                    if (s > 7)  begin s = 7;  v = 1'b1; end
                    if (s < -8) begin s = -8; v = 1'b1; end
                    r[4*i +: 4] = s[3:0];
                end
            end
        endcase
        e.id  = id;
        e.res = r;
        e.flg = full ? {r[15], v, (r == 16'h0)} : {fin[2:1], (r == 16'h0)};
        return e;
    endfunction

    // Monitor: checks the held response against the scoreboard head, then the grant.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        bit         occ;
        int         gp;
        exp_t       e;
        if (rst) begin
            chk("ready_in_rst", 32'(bus.req_ready), 32'(0));
            sb.delete();
            m_flag = 3'b000;
            m_rr_last = 1'b1;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            occ = (sb.size() != 0);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(occ));
            if (bus.rsp_valid && occ) begin
                e = sb[0];
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                chk("flag_q", 32'(flag_q), 32'(e.flg));
                if (bus.rsp_ready) void'(sb.pop_front());
            end
            gp = -1;
            if (!occ || bus.rsp_ready) begin
                if (bus.req_valid == 2'b11) gp = m_rr_last ? 0 : 1;
                else if (bus.req_valid[0]) gp = 0;
                else if (bus.req_valid[1]) gp = 1;
            end
            exp_rdy = (gp == 0) ? 2'b01 : (gp == 1) ? 2'b10 : 2'b00;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (gp == 0) begin
                e = ref_alu(1'b0, bus.req0_op, bus.req0_a, bus.req0_b, m_flag);
                m_cnt0++;
            end else if (gp == 1) begin
                e = ref_alu(1'b1, bus.req1_op, bus.req1_a, bus.req1_b, m_flag);
                m_cnt1++;
            end
            if (gp >= 0) begin
                sb.push_back(e);
                m_flag = e.flg;
                m_rr_last = e.id;
            end
        end
    end

    task automatic set_req(input logic p, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (p) begin bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; end
        else   begin bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; end
        bus.req_valid[p] = 1'b1;
    endtask

    // Present one request and hold it until accepted; returns just after the transfer edge.
    task automatic issue(input logic p, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        set_req(p, op, a, b);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready[p] && n < 20);
        checks++;
        if (!bus.req_ready[p]) begin
            errors++;
            $display("FAIL issue_timeout: port %0d not accepted within %0d cycles", p, n);
        end
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rnd_data();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        bus.req0_op = ALU_ADD; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222;
        bus.req1_op = ALU_SUB; bus.req1_a = 16'h3333; bus.req1_b = 16'h4444;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'(0));
        chk("rst_flag", 32'(flag_q), 32'(0));
        @(posedge clk); #1;

        // Directed ALU results and flag chaining.
        issue(1'b0, ALU_ADD, 16'h0010, 16'h0004);
        chk("add_valid", 32'(bus.rsp_valid), 32'(1));
        chk("add_id", 32'(bus.rsp_id), 32'(0));
        chk("add_res", 32'(bus.rsp_result), 32'h0014);
        chk("add_flag", 32'(flag_q), 32'(3'b000));
        issue(1'b1, ALU_SUB, 16'h0014, 16'h0014);
        chk("sub_id", 32'(bus.rsp_id), 32'(1));
        chk("sub_res", 32'(bus.rsp_result), 32'h0000);
        chk("sub_flag", 32'(flag_q), 32'(3'b001));
        issue(1'b0, ALU_ADD, 16'h7FFF, 16'h0001);
        chk("ovf_res", 32'(bus.rsp_result), 32'h8000);
        chk("ovf_flag", 32'(flag_q), 32'(3'b110));
        issue(1'b0, ALU_XOR, 16'hABCD, 16'hABCD);
        chk("xor_res", 32'(bus.rsp_result), 32'h0000);
        chk("xor_flag", 32'(flag_q), 32'(3'b111));

        // Round-robin with both ports continuously valid.
        do_reset();
        set_req(1'b0, ALU_ADD, 16'h0001, 16'h0001);
        set_req(1'b1, ALU_SUB, 16'h0005, 16'h0003);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        @(posedge clk); #1;

        // Backpressure: held response stays stable and blocks both ports.
        bus.rsp_ready = 1'b0;
        issue(1'b0, ALU_SUB, 16'h0100, 16'h0001);
        set_req(1'b1, ALU_XOR, 16'h0F00, 16'h000F);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(bus.req_ready), 32'(0));
            chk("stall_valid", 32'(bus.rsp_valid), 32'(1));
            chk("stall_id", 32'(bus.rsp_id), 32'(0));
            chk("stall_res", 32'(bus.rsp_result), 32'h00FF);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("drain_issue_ready", 32'(bus.req_ready), 32'(2'b10));
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        chk("drain_issue_valid", 32'(bus.rsp_valid), 32'(1));
        chk("drain_issue_id", 32'(bus.rsp_id), 32'(1));
        chk("drain_issue_res", 32'(bus.rsp_result), 32'h0F0F);

        // Reset while a flagged result is held.
        issue(1'b0, ALU_ADD, 16'h7FFF, 16'h0001);
        bus.rsp_ready = 1'b0;
        chk("pre_rst_flag", 32'(flag_q), 32'(3'b110));
        set_req(1'b0, ALU_ADD, 16'h0002, 16'h0002);
        set_req(1'b1, ALU_ADD, 16'h0003, 16'h0003);
        do_reset();
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'(0));
        chk("mid_rst_flag", 32'(flag_q), 32'(0));
        chk("mid_rst_grant", 32'(bus.req_ready), 32'(2'b01));
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;

        // Randomized traffic; requests are held until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            take = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!bus.req_valid[0] || take[0]) begin
                bus.req_valid[0] = ($urandom_range(0, 2) != 0);
                bus.req0_op = 3'($urandom_range(0, 7));
                bus.req0_a = rnd_data();
                bus.req0_b = rnd_data();
            end
            if (!bus.req_valid[1] || take[1]) begin
                bus.req_valid[1] = ($urandom_range(0, 2) != 0);
                bus.req1_op = 3'($urandom_range(0, 7));
                bus.req1_a = rnd_data();
                bus.req1_b = rnd_data();
            end
        end
        @(negedge clk);
        take = bus.req_valid & bus.req_ready;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("final_empty", 32'(sb.size()), 32'(0));
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
        chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
